// File: rtl/nested_epc_stack.sv
// nested_epc_stack
// LIFO of exception return addresses for CP0. Each exception commit pushes
// an entry and each ERET pops one. MTC0 and MFC0 access the top entry. The
// top entry drives the ERET target toward fetch.
// The storage is a circular buffer with a top pointer and a level count. A
// push into a full stack silently overwrites the oldest entry.
module nested_epc_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_p,
    input  logic             bd_p,
    input  logic [WIDTH-1:0] pc_p,
    input  logic             eret_p,
    input  logic             we_s,
    input  logic [WIDTH-1:0] write_data,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] read_data,
    output logic             read_bd,
    output logic [PTR_W:0]   level,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam logic [PTR_W:0] LEVEL_MAX = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] epc_mem [DEPTH];
    logic             bd_mem  [DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [WIDTH-1:0] push_epc;

    logic is_empty;
    logic is_full;
    logic do_push;
    logic do_pop;
    logic do_unf;
    logic do_wr_top;
    logic do_wr_new;

    assign is_empty = (level == '0);
    assign is_full  = (level == LEVEL_MAX);
    assign top_inc  = top + PTR_W'(1);
    assign top_dec  = top - PTR_W'(1);

    // A fault in a delay slot resumes at the branch, so the EPC is backed up by one instruction
    assign push_epc = bd_p ? (pc_p - WIDTH'(4)) : pc_p;

    // Only one action is taken per edge. An exception wins over ERET, and ERET wins over MTC0
    assign do_push   = exc_p;
    assign do_pop    = !exc_p && eret_p && !is_empty;
    assign do_unf    = !exc_p && eret_p && is_empty;
    assign do_wr_top = !exc_p && !eret_p && we_s && !is_empty;
    assign do_wr_new = !exc_p && !eret_p && we_s && is_empty;

    // Entry storage. Pushes land above the top, MTC0 edits the top, and a pop zeroes the vacated slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                epc_mem[i] <= '0;
                bd_mem[i]  <= 1'b0;
            end
        end else if (do_push) begin
            epc_mem[top_inc] <= push_epc;
            bd_mem[top_inc]  <= bd_p;
        end else if (do_wr_new) begin
            epc_mem[top_inc] <= write_data;
            bd_mem[top_inc]  <= 1'b0;
        end else if (do_wr_top) begin
            epc_mem[top] <= write_data;
        end else if (do_pop) begin
            epc_mem[top] <= '0;
            bd_mem[top]  <= 1'b0;
        end
    end

    // Top pointer and level. The level saturates at DEPTH while the pointer keeps wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top   <= '0;
            level <= '0;
        end else if (do_push || do_wr_new) begin
            top <= top_inc;
            if (!is_full) begin
                level <= level + 1'b1;
            end
        end else if (do_pop) begin
            top   <= top_dec;
            level <= level - 1'b1;
        end
    end

    // Sticky overflow/underflow flags. A new event in the same cycle takes precedence over flag_clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (flag_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (do_push && is_full) begin
                ovf <= 1'b1;
            end
            if (do_unf) begin
                unf <= 1'b1;
            end
        end
    end

    // The top entry is exposed directly. It is forced to zero when the stack holds nothing
    always_comb begin
        read_data = '0;
        read_bd   = 1'b0;
        if (!is_empty) begin
            read_data = epc_mem[top];
            read_bd   = bd_mem[top];
        end
    end

    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: tb/tb_nested_epc_stack.sv
// tb_nested_epc_stack
// Directed bench for the nested EPC stack. Each step drives the inputs for one
// edge and queues the outputs expected after that edge. The queued entries are
// then popped and compared against the DUT once it has updated.
module tb_nested_epc_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    localparam int SEL_DATA  = 0;
    localparam int SEL_BD    = 1;
    localparam int SEL_LEVEL = 2;
    localparam int SEL_EMPTY = 3;
    localparam int SEL_FULL  = 4;
    localparam int SEL_OVF   = 5;
    localparam int SEL_UNF   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             exc_p;
    logic             bd_p;
    logic [WIDTH-1:0] pc_p;
    logic             eret_p;
    logic             we_s;
    logic [WIDTH-1:0] write_data;
    logic             flag_clr;
    logic [WIDTH-1:0] read_data;
    logic             read_bd;
    logic [PTR_W:0]   level;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    int compared   = 0;
    int mismatched = 0;

    string       tag_q [$];
    int          sel_q [$];
    logic [31:0] exp_q [$];

    nested_epc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .exc_p      (exc_p),
        .bd_p       (bd_p),
        .pc_p       (pc_p),
        .eret_p     (eret_p),
        .we_s       (we_s),
        .write_data (write_data),
        .flag_clr   (flag_clr),
        .read_data  (read_data),
        .read_bd    (read_bd),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .ovf        (ovf),
        .unf        (unf)
    );

    // Free-running clock with a 10-unit period
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_DATA:  return read_data;
            SEL_BD:    return {31'd0, read_bd};
            SEL_LEVEL: return {29'd0, level};
            SEL_EMPTY: return {31'd0, empty};
            SEL_FULL:  return {31'd0, full};
            SEL_OVF:   return {31'd0, ovf};
            SEL_UNF:   return {31'd0, unf};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    task automatic expect_reset_state(input string tag);
        expect_out({tag, ".data"},  SEL_DATA,  32'h0);
        expect_out({tag, ".bd"},    SEL_BD,    32'h0);
        expect_out({tag, ".level"}, SEL_LEVEL, 32'h0);
        expect_out({tag, ".empty"}, SEL_EMPTY, 32'h1);
        expect_out({tag, ".full"},  SEL_FULL,  32'h0);
        expect_out({tag, ".ovf"},   SEL_OVF,   32'h0);
        expect_out({tag, ".unf"},   SEL_UNF,   32'h0);
    endtask

    task automatic check_output();
        string       tag;
        int          sel;
        logic [31:0] exp_v;
        logic [31:0] obs_v;
        while (tag_q.size() > 0) begin
            tag   = tag_q.pop_front();
            sel   = sel_q.pop_front();
            exp_v = exp_q.pop_front();
            obs_v = observe(sel);
            compared++;
            assert (obs_v === exp_v) else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
            end
        end
    endtask

    task automatic apply_stimulus(input logic exc, input logic bd, input logic [31:0] pc,
                                  input logic eret, input logic we, input logic [31:0] wd,
                                  input logic clr);
        exc_p      = exc;
        bd_p       = bd;
        pc_p       = pc;
        eret_p     = eret;
        we_s       = we;
        write_data = wd;
        flag_clr   = clr;
    endtask

    task automatic idle_inputs();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Advances one edge, returns the inputs to idle, then checks everything that was queued
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
        check_output();
    endtask

    task automatic push(input logic bd, input logic [31:0] pc);
        apply_stimulus(1'b1, bd, pc, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic eret();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic mtc0(input logic [31:0] wd);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, wd, 1'b0);
    endtask

    // Linear sequence of directed steps
    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        expect_reset_state("reset");
        check_output();
        rst = 1'b1;
        step();

        // Two nested exceptions, the second one in a delay slot, followed by one ERET
        push(1'b0, 32'h8000_0100);
        expect_out("t1.push1.data",  SEL_DATA,  32'h8000_0100);
        expect_out("t1.push1.level", SEL_LEVEL, 32'd1);
        step();
        push(1'b1, 32'h8000_0204);
        expect_out("t1.push2.data",  SEL_DATA,  32'h8000_0200);
        expect_out("t1.push2.bd",    SEL_BD,    32'h1);
        expect_out("t1.push2.level", SEL_LEVEL, 32'd2);
        step();
        eret();
        expect_out("t1.eret.data",  SEL_DATA,  32'h8000_0100);
        expect_out("t1.eret.bd",    SEL_BD,    32'h0);
        expect_out("t1.eret.level", SEL_LEVEL, 32'd1);
        step();
        eret();
        expect_out("t1.drain.empty", SEL_EMPTY, 32'h1);
        expect_out("t1.drain.data",  SEL_DATA,  32'h0);
        step();

        // Overflow: five pushes into four slots wrap the pointer and drop the oldest entry
        for (int i = 1; i <= 5; i++) begin
            push(1'b0, 32'(i * 16));
            expect_out("t2.push.data",  SEL_DATA,  32'(i * 16));
            expect_out("t2.push.level", SEL_LEVEL, (i < 4) ? 32'(i) : 32'd4);
            expect_out("t2.push.full",  SEL_FULL,  (i >= 4) ? 32'h1 : 32'h0);
            expect_out("t2.push.ovf",   SEL_OVF,   (i == 5) ? 32'h1 : 32'h0);
            step();
        end
        for (int i = 4; i >= 1; i--) begin
            eret();
            expect_out("t2.pop.data",  SEL_DATA,  (i > 1) ? 32'(i * 16) : 32'h0);
            expect_out("t2.pop.level", SEL_LEVEL, 32'(i - 1));
            step();
        end
        expect_out("t2.final.empty", SEL_EMPTY, 32'h1);
        expect_out("t2.final.ovf",   SEL_OVF,   32'h1);
        check_output();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_out("t2.clr.ovf", SEL_OVF, 32'h0);
        step();

        // Underflow stays set when a flag clear coincides with another empty ERET
        eret();
        expect_out("t3.unf",   SEL_UNF,   32'h1);
        expect_out("t3.level", SEL_LEVEL, 32'd0);
        expect_out("t3.data",  SEL_DATA,  32'h0);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_out("t3.clr_vs_set.unf", SEL_UNF, 32'h1);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_out("t3.clr.unf", SEL_UNF, 32'h0);
        step();

        // Priority: an exception wins over ERET and MTC0, and ERET wins over MTC0
        push(1'b0, 32'h0000_0100);
        expect_out("t4.base.level", SEL_LEVEL, 32'd1);
        step();
        apply_stimulus(1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("t4.exc_eret.level", SEL_LEVEL, 32'd2);
        expect_out("t4.exc_eret.data",  SEL_DATA,  32'h0000_0200);
        step();
        apply_stimulus(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0);
        expect_out("t4.exc_we.level", SEL_LEVEL, 32'd3);
        expect_out("t4.exc_we.data",  SEL_DATA,  32'h0000_02FC);
        expect_out("t4.exc_we.bd",    SEL_BD,    32'h1);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_1111, 1'b0);
        expect_out("t4.eret_we.level", SEL_LEVEL, 32'd2);
        expect_out("t4.eret_we.data",  SEL_DATA,  32'h0000_0200);
        step();
        eret();
        step();
        eret();
        expect_out("t4.drain.empty", SEL_EMPTY, 32'h1);
        step();

        // MTC0 on an empty stack creates an entry, and on a non-empty stack it edits only the top EPC
        mtc0(32'hBFC0_0000);
        expect_out("t5.new.level", SEL_LEVEL, 32'd1);
        expect_out("t5.new.data",  SEL_DATA,  32'hBFC0_0000);
        expect_out("t5.new.bd",    SEL_BD,    32'h0);
        step();
        mtc0(32'h0000_1234);
        expect_out("t5.edit.level", SEL_LEVEL, 32'd1);
        expect_out("t5.edit.data",  SEL_DATA,  32'h0000_1234);
        step();
        push(1'b1, 32'h0000_0000);
        expect_out("t5.wrap_pc.data", SEL_DATA, 32'hFFFF_FFFC);
        expect_out("t5.wrap_pc.bd",   SEL_BD,   32'h1);
        step();
        mtc0(32'h0000_0099);
        expect_out("t5.keep_bd.data", SEL_DATA, 32'h0000_0099);
        expect_out("t5.keep_bd.bd",   SEL_BD,   32'h1);
        step();
        eret();
        expect_out("t5.pop.data", SEL_DATA, 32'h0000_1234);
        step();
        eret();
        step();

        // Asynchronous reset applied between edges at level 3 with ovf set
        for (int i = 1; i <= 5; i++) begin
            push(1'b0, 32'h1000 + 32'(i));
            step();
        end
        eret();
        expect_out("t6.pre.level", SEL_LEVEL, 32'd3);
        expect_out("t6.pre.ovf",   SEL_OVF,   32'h1);
        step();
        push(1'b0, 32'h0000_0555);
        #2;
        rst = 1'b0;
        #1;
        expect_reset_state("t6.async");
        check_output();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(1'b0, 32'h0000_0077);
        expect_out("t6.after.level", SEL_LEVEL, 32'd1);
        expect_out("t6.after.data",  SEL_DATA,  32'h0000_0077);
        step();
        eret();
        expect_reset_state("t6.cleared");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
